// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter and related
// shared-datapath arbiters.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int unsigned DW_DEFAULT             = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Index width for n entries, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared multiplier.
// master is the arbiter's view; slave is the surrounding environment's view.
interface mult_share_arbiter_if
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = DW_DEFAULT
) ();

    logic [NUM_REQ-1:0]      req_start_sig;
    logic [NUM_REQ*DW-1:0]   req_multiplicand;
    logic [NUM_REQ*DW-1:0]   req_multiplier;
    logic [NUM_REQ-1:0]      req_done_sig;
    logic [NUM_REQ-1:0]      req_err_sig;
    logic [NUM_REQ*2*DW-1:0] req_product;

    logic                    mul_start_sig;
    logic [DW-1:0]           mul_multiplicand;
    logic [DW-1:0]           mul_multiplier;
    logic                    mul_done_sig;
    logic [2*DW-1:0]         mul_product;

    modport master (
        input  req_start_sig, req_multiplicand, req_multiplier,
        input  mul_done_sig, mul_product,
        output req_done_sig, req_err_sig, req_product,
        output mul_start_sig, mul_multiplicand, mul_multiplier
    );

    modport slave (
        output req_start_sig, req_multiplicand, req_multiplier,
        output mul_done_sig, mul_product,
        input  req_done_sig, req_err_sig, req_product,
        input  mul_start_sig, mul_multiplicand, mul_multiplier
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request strictly after last_i, wrapping.
// Purely combinational; reusable by any shared-datapath arbiter.
module rr_priority_picker
    import mult_share_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          found_o,
    output logic [IW-1:0] next_idx_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        found_o    = 1'b0;
        next_idx_o = '0;
        // Wrapped range first; the range above last_i then overrides it.
        for (int j = N - 1; j >= 0; j--) begin
            if (req_i[j] && (IW'(j) <= last_i)) begin
                found_o    = 1'b1;
                next_idx_o = IW'(j);
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req_i[j] && (IW'(j) > last_i)) begin
                found_o    = 1'b1;
                next_idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/done multiplier among NUM_REQ requesters with round-robin
// grant, operand latching, per-requester product registers and a watchdog.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned  NUM_REQ        = 4,
    parameter int unsigned  DW             = DW_DEFAULT,
    parameter int unsigned  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int unsigned IW             = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.master bus,
    output logic                 busy,
    output logic [IW-1:0]        grant_idx
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned CW = clog2(TIMEOUT_CYCLES);

    state_e                state_q;
    logic [IW-1:0]         last_q;
    logic [IW-1:0]         grant_q;
    logic [DW-1:0]         mcand_q;
    logic [DW-1:0]         mplier_q;
    logic                  mul_start_q;
    logic                  busy_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    err_q;
    logic [NUM_REQ-1:0]    rearm_q;
    logic [NUM_REQ*PW-1:0] product_q;
    logic [CW-1:0]         wdog_q;

    logic [NUM_REQ-1:0]    eligible;
    logic                  found;
    logic [IW-1:0]         next_idx;

    // A served requester stays masked until it drops start, so a stale level is never re-granted.
    assign eligible = bus.req_start_sig & ~rearm_q;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_i      (eligible),
        .last_i     (last_q),
        .found_o    (found),
        .next_idx_o (next_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            grant_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
            err_q       <= '0;
            rearm_q     <= '0;
            // NOTE: product slices are ordinary flops, not a RAM, so they take reset like any other output.
            product_q   <= '0;
            wdog_q      <= '0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in this block overrides these defaults.
            done_q  <= '0;
            err_q   <= '0;
            rearm_q <= rearm_q & bus.req_start_sig;

            case (state_q)
                IDLE: begin
                    if (found) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (IW'(i) == next_idx) begin
                                mcand_q  <= bus.req_multiplicand[i*DW +: DW];
                                mplier_q <= bus.req_multiplier[i*DW +: DW];
                            end
                        end
                        grant_q     <= next_idx;
                        last_q      <= next_idx;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= BUSY;
                    end
                end

                BUSY: begin
                    // Done wins over a coincident timeout.
                    if (bus.mul_done_sig || (wdog_q == CW'(TIMEOUT_CYCLES - 1))) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (IW'(i) == grant_q) begin
                                product_q[i*PW +: PW] <= bus.mul_done_sig ? bus.mul_product : '0;
                                done_q[i]             <= 1'b1;
                                err_q[i]              <= !bus.mul_done_sig;
                                rearm_q[i]            <= 1'b1;
                            end
                        end
                        mul_start_q <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= RELEASE;
                    end else begin
                        wdog_q <= wdog_q + CW'(1);
                    end
                end

                RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    mul_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_done_sig     = done_q;
    assign bus.req_err_sig      = err_q;
    assign bus.req_product      = product_q;
    assign bus.mul_start_sig    = mul_start_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_multiplier   = mplier_q;
    assign busy                 = busy_q;
    assign grant_idx            = grant_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a small start/done multiplier
// stub that can hang or raise a spurious done.
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned TMO     = 16;
    localparam int          MUL_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] grant_idx;

    mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

    mult_share_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DW             (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    // Multiplier stub: done rises MUL_LAT edges after start, falls once start drops.
    logic        model_done;
    logic [15:0] model_prod;
    logic [15:0] ma, mb;
    int          mcnt;
    bit          hang;
    bit          spur_done;

    assign ma = {{8{bus.mul_multiplicand[7]}}, bus.mul_multiplicand};
    assign mb = {{8{bus.mul_multiplier[7]}}, bus.mul_multiplier};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b0;
            model_prod <= '0;
            mcnt       <= 0;
        end else if (!bus.mul_start_sig) begin
            model_done <= 1'b0;
            mcnt       <= 0;
        end else if (!model_done && !hang) begin
            if (mcnt == MUL_LAT - 1) begin
                model_done <= 1'b1;
                model_prod <= ma * mb;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    assign bus.mul_done_sig = model_done | spur_done;
    assign bus.mul_product  = spur_done ? 16'hDEAD : model_prod;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] prod(input int i);
        return bus.req_product[i*16 +: 16];
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_multiplicand[i*8 +: 8] = a;
        bus.req_multiplier[i*8 +: 8]   = b;
        bus.req_start_sig[i]           = 1'b1;
    endtask

    task automatic wait_done(input int idx, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.req_done_sig[idx]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit seen;
        int cnt;
        int order[$];
        int exp_order[5];
        bit [3:0] reassert;

        bus.req_start_sig    = '0;
        bus.req_multiplicand = '0;
        bus.req_multiplier   = '0;
        hang                 = 1'b0;
        spur_done            = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_mul_start", 64'(bus.mul_start_sig), 64'd0);
        check("rst_done", 64'(bus.req_done_sig), 64'd0);
        check("rst_product", bus.req_product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single requester 0, 10*2
        set_req(0, 8'd10, 8'd2);
        @(negedge clk);
        check("t1_mul_start", 64'(bus.mul_start_sig), 64'd1);
        check("t1_mcand", 64'(bus.mul_multiplicand), 64'd10);
        check("t1_mplier", 64'(bus.mul_multiplier), 64'd2);
        check("t1_grant_idx", 64'(grant_idx), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(0, 20, seen);
        check("t1_done_seen", 64'(seen), 64'd1);
        check("t1_err", 64'(bus.req_err_sig), 64'd0);
        check("t1_prod0", 64'(prod(0)), 64'd20);
        check("t1_busy_in_release", 64'(busy), 64'd1);
        bus.req_start_sig[0] = 1'b0;
        @(negedge clk);
        check("t1_done_once", 64'(bus.req_done_sig), 64'd0);
        check("t1_busy_fall", 64'(busy), 64'd0);

        // T2: requesters 1 and 2 together, pointer at 0
        set_req(1, 8'd2, 8'd10);
        set_req(2, 8'd11, 8'hFB);
        wait_done(1, 20, seen);
        check("t2_done1_seen", 64'(seen), 64'd1);
        check("t2_grant1", 64'(grant_idx), 64'd1);
        check("t2_prod1", 64'(prod(1)), 64'h0014);
        bus.req_start_sig[1] = 1'b0;
        wait_done(2, 20, seen);
        check("t2_done2_seen", 64'(seen), 64'd1);
        check("t2_grant2", 64'(grant_idx), 64'd2);
        check("t2_prod2", 64'(prod(2)), 64'hFFC9);
        bus.req_start_sig[2] = 1'b0;
        @(negedge clk);

        // T5: asynchronous reset mid-BUSY
        set_req(3, 8'd4, 8'd4);
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd1);
        check("t5_grant3", 64'(grant_idx), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_mul_start", 64'(bus.mul_start_sig), 64'd0);
        check("t5_rst_grant", 64'(grant_idx), 64'd0);
        check("t5_rst_mcand", 64'(bus.mul_multiplicand), 64'd0);
        check("t5_rst_product", bus.req_product, 64'd0);
        check("t5_rst_done", 64'(bus.req_done_sig), 64'd0);
        bus.req_start_sig = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.req_done_sig != '0) cnt++;
        end
        check("t5_no_done_after_reset", 64'(cnt), 64'd0);

        // T3: all four continuously requesting; pointer fresh from reset
        set_req(0, 8'd3, 8'd4);
        set_req(1, 8'd2, 8'd10);
        set_req(2, 8'd11, 8'hFB);
        set_req(3, 8'hFB, 8'hF5);
        reassert = '0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (reassert[i]) begin
                    bus.req_start_sig[i] = 1'b1;
                    reassert[i] = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.req_done_sig[i]) begin
                    order.push_back(i);
                    bus.req_start_sig[i] = 1'b0;
                    reassert[i] = 1'b1;
                end
            end
        end
        bus.req_start_sig = '0;
        exp_order = '{0, 1, 2, 3, 0};
        check("t3_num_served", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_order%0d", k),
                  64'(k < order.size() ? order[k] : -1), 64'(exp_order[k]));
        end
        @(negedge clk);
        check("t3_idle_after", 64'(busy), 64'd0);
        check("t3_products", bus.req_product, 64'h0037_FFC9_0014_000C);

        // T4: hung multiplier, watchdog after 16 BUSY cycles
        hang = 1'b1;
        set_req(3, 8'd7, 8'd7);
        seen = 1'b0;
        cnt  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req_done_sig[3]) begin
                seen = 1'b1;
                break;
            end
            if (bus.mul_start_sig) cnt++;
        end
        check("t4_done_seen", 64'(seen), 64'd1);
        check("t4_busy_cycles", 64'(cnt), 64'd16);
        check("t4_done_vec", 64'(bus.req_done_sig), 64'b1000);
        check("t4_err_vec", 64'(bus.req_err_sig), 64'b1000);
        check("t4_prod3_zero", 64'(prod(3)), 64'd0);
        check("t4_mul_start_low", 64'(bus.mul_start_sig), 64'd0);
        bus.req_start_sig[3] = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        check("t4_err_once", 64'(bus.req_err_sig), 64'd0);
        set_req(1, 8'd6, 8'd7);
        wait_done(1, 20, seen);
        check("t4_next_done_seen", 64'(seen), 64'd1);
        check("t4_next_grant", 64'(grant_idx), 64'd1);
        check("t4_next_err", 64'(bus.req_err_sig), 64'd0);
        check("t4_next_prod1", 64'(prod(1)), 64'h002A);
        bus.req_start_sig[1] = 1'b0;
        @(negedge clk);

        // T6: spurious done in IDLE, then start held through RELEASE
        spur_done = 1'b1;
        cnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (bus.req_done_sig != '0 || busy) cnt++;
        end
        spur_done = 1'b0;
        check("t6_spurious_no_done", 64'(cnt), 64'd0);
        check("t6_spurious_products", bus.req_product, 64'h0000_FFC9_002A_000C);
        set_req(0, 8'd5, 8'd3);
        wait_done(0, 20, seen);
        check("t6_held_done_seen", 64'(seen), 64'd1);
        check("t6_held_prod0", 64'(prod(0)), 64'h000F);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || bus.mul_start_sig || bus.req_done_sig != '0) cnt++;
        end
        check("t6_no_regrant_stale", 64'(cnt), 64'd0);
        bus.req_start_sig[0] = 1'b0;
        @(negedge clk);
        set_req(0, 8'd9, 8'd9);
        wait_done(0, 20, seen);
        check("t6_rearm_done_seen", 64'(seen), 64'd1);
        check("t6_rearm_prod0", 64'(prod(0)), 64'h0051);
        bus.req_start_sig[0] = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
